// File: rtl/stacker_pkg.sv
// Shared types and widths for the stacker game datapath.
// Used by the row mover and its frame divider.
package stacker_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_CHECK
    } state_t;

    localparam int COLS_DEFAULT = 16;
    localparam int SPD_W        = 11;
    localparam int NB_W         = 4;

endpackage

// File: rtl/frame_divider.sv
// Counts frame ticks and emits a step pulse every spd ticks.
// step is combinational so the caller moves on the same edge.
module frame_divider
    import stacker_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic [SPD_W-1:0] spd,
    input  logic             clr,
    output logic             step
);

    logic [SPD_W-1:0] frame_cnt;
    logic [SPD_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, frame_cnt} + 1'b1;
    assign step    = tick && (cnt_inc >= {1'b0, spd});

    // frame counter: cleared on start, wraps to 0 on step, saturates otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt <= '0;
        end else if (clr) begin
            frame_cnt <= '0;
        end else if (tick) begin
            if (step) begin
                frame_cnt <= '0;
            end else if (frame_cnt != '1) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_row_mover.sv
// Bouncing row of lit cells for the stacker game; on stop the
// frozen row is intersected with the support row below it.
module block_row_mover
    import stacker_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             go,
    input  logic             stop,
    input  logic [SPD_W-1:0] speed_count,
    input  logic [NB_W-1:0]  num_blocks,
    input  logic [5:0]       curr_level,
    output logic [COLS-1:0]  row_mask,
    output logic [COLS-1:0]  placed_mask,
    output logic             next_signal,
    output logic             fail,
    output logic             busy
);

    localparam int PW = $clog2(COLS);
    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    state_t           state;
    logic [SPD_W-1:0] spd;
    logic [5:0]       wid;
    logic [PW-1:0]    pos;
    logic             dir;
    logic [COLS-1:0]  captured;

    logic [SPD_W-1:0] spd_in;
    logic [5:0]       nb6;
    logic [5:0]       wid_in;
    logic [5:0]       maxpos;
    logic [6:0]       pos7;
    logic [6:0]       end7;
    logic [COLS-1:0]  ov;
    logic             tick_en;
    logic             clr;
    logic             step;

    assign spd_in = (speed_count == '0) ? SPD_W'(1) : speed_count;
    assign nb6    = 6'(num_blocks);
    assign wid_in = (nb6 == 6'd0)      ? 6'd1 :
                    (nb6 > 6'(COLS))   ? 6'(COLS) : nb6;

    assign maxpos  = 6'(COLS) - wid;
    assign pos7    = 7'(pos);
    assign end7    = pos7 + 7'(wid);
    assign ov      = captured & placed_mask;
    assign busy    = (state != S_IDLE);
    assign tick_en = (state == S_MOVE) && frame_tick && !stop;
    assign clr     = (state == S_IDLE) && go;

    frame_divider u_div (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick_en),
        .spd    (spd),
        .clr    (clr),
        .step   (step)
    );

    // lit cells span [pos, pos+wid) while a row is active
    always_comb begin
        row_mask = '0;
        for (int i = 0; i < COLS; i++) begin
            row_mask[i] = busy && (7'(i) >= pos7) && (7'(i) < end7);
        end
    end

    // row FSM: start, bounce, freeze and compare against the support row
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            spd         <= SPD_W'(1);
            wid         <= 6'd1;
            pos         <= '0;
            dir         <= DIR_R;
            captured    <= '0;
            placed_mask <= '1;
            next_signal <= 1'b0;
            fail        <= 1'b0;
        end else begin
            next_signal <= 1'b0;
            fail        <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        spd   <= spd_in;
                        wid   <= wid_in;
                        pos   <= '0;
                        dir   <= DIR_R;
                        state <= S_MOVE;
                        if (curr_level == 6'd1) begin
                            placed_mask <= '1;
                        end
                    end
                end
                S_MOVE: begin
                    if (stop) begin
                        captured <= row_mask;
                        state    <= S_CHECK;
                    end else if (step) begin
                        if (maxpos == 6'd0) begin
                            pos <= '0;
                        end else if (dir == DIR_R) begin
                            if (6'(pos) == maxpos) begin
                                dir <= DIR_L;
                                pos <= pos - 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                dir <= DIR_R;
                                pos <= pos + 1'b1;
                            end else begin
                                pos <= pos - 1'b1;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (ov != '0) begin
                        placed_mask <= ov;
                        next_signal <= 1'b1;
                    end else begin
                        placed_mask <= '1;
                        fail        <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_row_mover.sv
// Directed bench for block_row_mover with hand-computed masks.
module tb_block_row_mover;

    logic        clk;
    logic        resetn;
    logic        frame_tick;
    logic        go;
    logic        stop;
    logic [10:0] speed_count;
    logic [3:0]  num_blocks;
    logic [5:0]  curr_level;
    logic [15:0] row_mask;
    logic [15:0] placed_mask;
    logic        next_signal;
    logic        fail;
    logic        busy;

    int total = 0;
    int bad   = 0;

    block_row_mover #(.COLS(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .go          (go),
        .stop        (stop),
        .speed_count (speed_count),
        .num_blocks  (num_blocks),
        .curr_level  (curr_level),
        .row_mask    (row_mask),
        .placed_mask (placed_mask),
        .next_signal (next_signal),
        .fail        (fail),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [10:0] s, input logic [3:0] nb,
                         input logic [5:0] lvl);
        speed_count = s;
        num_blocks  = nb;
        curr_level  = lvl;
        go = 1'b1;
        cyc(1);
        go = 1'b0;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        cyc(n);
        frame_tick = 1'b0;
    endtask

    task automatic do_stop(input string tag, input logic exp_next,
                           input logic [15:0] exp_placed);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        frame_tick = 1'b0;
        check({tag, "_chk_busy"}, busy, 1'b1);
        check({tag, "_chk_nopulse"}, {next_signal, fail}, 2'b00);
        cyc(1);
        check({tag, "_next"}, next_signal, exp_next);
        check({tag, "_fail"}, fail, !exp_next);
        check({tag, "_placed"}, placed_mask, exp_placed);
        cyc(1);
        check({tag, "_after"}, {busy, next_signal, fail}, 3'b000);
        check({tag, "_rowoff"}, row_mask, 16'h0000);
    endtask

    initial begin
        resetn      = 1'b0;
        frame_tick  = 1'b0;
        go          = 1'b0;
        stop        = 1'b0;
        speed_count = 11'd0;
        num_blocks  = 4'd0;
        curr_level  = 6'd1;
        cyc(2);
        resetn = 1'b1;
        cyc(1);

        check("rst_row", row_mask, 16'h0000);
        check("rst_placed", placed_mask, 16'hFFFF);
        check("rst_busy", busy, 1'b0);
        check("rst_pulse", {next_signal, fail}, 2'b00);

        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
        check("idle_stop", {busy, next_signal, fail}, 3'b000);

        start(11'd2, 4'd3, 6'd1);
        check("r1_busy", busy, 1'b1);
        check("r1_p0", row_mask, 16'h0007);
        ticks(1);
        check("r1_t1", row_mask, 16'h0007);
        ticks(1);
        check("r1_p1", row_mask, 16'h000E);
        ticks(24);
        check("r1_p13", row_mask, 16'hE000);
        ticks(2);
        check("r1_p12", row_mask, 16'h7000);
        ticks(2);
        check("r1_p11", row_mask, 16'h3800);
        ticks(14);
        check("r1_p4", row_mask, 16'h0070);
        do_stop("r1", 1'b1, 16'h0070);

        start(11'd2, 4'd3, 6'd2);
        ticks(12);
        check("r2_p6", row_mask, 16'h01C0);
        do_stop("r2", 1'b1, 16'h0040);

        start(11'd2, 4'd1, 6'd3);
        check("r3_p0", row_mask, 16'h0001);
        do_stop("r3", 1'b0, 16'hFFFF);

        start(11'd1, 4'd2, 6'd1);
        ticks(3);
        check("st_p3", row_mask, 16'h0018);
        frame_tick = 1'b1;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        frame_tick = 1'b0;
        check("st_frozen", row_mask, 16'h0018);
        cyc(1);
        check("st_next", next_signal, 1'b1);
        check("st_placed", placed_mask, 16'h0018);
        cyc(1);

        start(11'd1, 4'd0, 6'd1);
        check("nb0_p0", row_mask, 16'h0001);
        ticks(1);
        check("nb0_p1", row_mask, 16'h0002);
        do_stop("nb0", 1'b1, 16'h0002);

        start(11'd0, 4'd15, 6'd1);
        check("w15_placed", placed_mask, 16'hFFFF);
        check("w15_p0", row_mask, 16'h7FFF);
        ticks(1);
        check("w15_p1", row_mask, 16'hFFFE);
        ticks(1);
        check("w15_back", row_mask, 16'h7FFF);
        ticks(1);
        check("w15_again", row_mask, 16'hFFFE);
        go = 1'b1;
        num_blocks = 4'd3;
        cyc(1);
        go = 1'b0;
        check("go_ignored", row_mask, 16'hFFFE);

        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_row", row_mask, 16'h0000);
        cyc(1);
        resetn = 1'b1;
        cyc(2);
        check("arst_pulse", {busy, next_signal, fail}, 3'b000);
        check("arst_placed", placed_mask, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_row_mover.md
# block_row_mover

Consumes the level controller's `speed_count` and `num_blocks` and animates the active row of the stacker: a contiguous run of lit cells bouncing left/right across the playfield, one cell per `speed_count` frames. On the player's stop press it compares the frozen row against the stack below. It then reports success (`next_signal`, fed back to the level controller) or failure, and keeps the surviving overlap as the new support row.

## Interface
- `COLS`, 16, playfield width in cells (2..32)
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset; one clock domain
- `frame_tick`  in  1  one-cycle pulse per video frame (60 Hz)
- `go`  in  1  start a new row (pulse or level; sampled in IDLE only)
- `stop`  in  1  player stop press, one-cycle pulse
- `speed_count`  in  11  frames per step; 0 treated as 1
- `num_blocks`  in  4  moving run width; 0 treated as 1, clamped to `COLS`
- `curr_level`  in  6  level number; 1 means a fresh stack
- `row_mask`  out  COLS  lit cells of the moving row; bit 0 = leftmost
- `placed_mask`  out  COLS  support row below; all ones means ground
- `next_signal`  out  1  one-cycle pulse, row landed with nonzero overlap
- `fail`  out  1  one-cycle pulse, row missed completely
- `busy`  out  1  high in MOVE and CHECK

## Operation
- States: IDLE, MOVE, CHECK.
- IDLE, `go`=1:
  - latch `spd` = max(`speed_count`,1) and `wid` = clamp(`num_blocks`,1,`COLS`)
  - `pos`<=0, `dir`<=right, `frame_cnt`<=0
  - if `curr_level`==1, `placed_mask`<=all ones
  - go to MOVE
- `row_mask` = ((1<<`wid`)-1) << `pos` in MOVE/CHECK; 0 in IDLE. `maxpos` = `COLS`-`wid`.
- MOVE, `frame_tick` without `stop`:
  - if `frame_cnt`+1 >= `spd`, step and set `frame_cnt`<=0; otherwise increment `frame_cnt`
  - step right: if `pos`==`maxpos`, `dir`<=left and `pos`<=`pos`-1; otherwise `pos`+1
  - step left mirrors this at 0
  - if `maxpos`==0, `pos` stays 0
- MOVE, `stop`=1: `captured`<=`row_mask`; go to CHECK. `stop` beats a simultaneous `frame_tick`, so the pre-step position is captured.
- CHECK, one cycle: `ov` = `captured` & `placed_mask`.
  - `ov`!=0: `placed_mask`<=`ov`, `next_signal`<=1
  - `ov`==0: `placed_mask`<=all ones, `fail`<=1
  - go to IDLE
- `stop` outside MOVE and `go` outside IDLE are ignored.
- `speed_count`/`num_blocks` changes mid-row have no effect until the next `go`.
- All arithmetic is unsigned. `pos` is $clog2(`COLS`) bits. `frame_cnt` is 11 bits and saturates, never wraps.

## Timing
- Reset values:
  - state IDLE, `pos` 0, `dir` right, `frame_cnt` 0
  - `row_mask` 0, `placed_mask` all ones
  - `next_signal` 0, `fail` 0, `busy` 0
- `go` sampled at edge k: MOVE and a valid `row_mask` from k+1.
- `stop` sampled at edge k: row frozen from k+1; `next_signal`/`fail` high for exactly the cycle after edge k+1; IDLE from k+2.
- Reset asserted mid-row returns to IDLE immediately and asynchronously, with no result pulse.
- Step cadence: first step on the `spd`-th `frame_tick` after entering MOVE.

## Structure
- Shared package `stacker_pkg` holds:
  - state enum (IDLE/MOVE/CHECK)
  - default `COLS`
  - width constants for `speed_count` (11) and `num_blocks` (4)
- One natural sub-module: `frame_divider`. It takes `frame_tick`, `spd` and a clear input, and outputs a one-cycle `step` pulse (the `frame_cnt` logic).
- Mask generation, bounce and compare logic stay in the top level.

## Test plan
- Reset, then idle: `row_mask`=0, `placed_mask`=16'hFFFF, `busy`=0, no pulses.
- `go` with `speed_count`=2, `num_blocks`=3, `curr_level`=1; 30 ticks:
  - `pos` steps every 2nd tick, 0→13 then back to 12, 11…
  - `row_mask` at pos 13 = 16'hE000
- `stop` at pos 4, wid 3 over ground: `next_signal` pulses 2 cycles later; `placed_mask`=16'h0070.
- Next row, wid 3, `stop` at pos 6: overlap 16'h0040, `next_signal`. Then `stop` at pos 0 with wid 1: `fail` pulses and `placed_mask`=16'hFFFF.
- `stop` and `frame_tick` in the same cycle with the step due: captured `pos` is the pre-step value.
- Edge cases:
  - `num_blocks`=0 behaves as 1
  - `num_blocks`=15, `COLS`=16 bounces between 0 and 1
  - `speed_count`=0 steps every tick
  - reset mid-MOVE yields IDLE with no pulse
